// File: rtl/score_scan_mux.sv
// Two-player BCD score keeper with win detection and 4-digit multiplexed display drive.
// Define LEADING_ZERO_BLANK_EN to blank a zero tens digit with BLANK_CODE.
module score_scan_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned WIN_SCORE   = 11,
  parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       clr_scores,
  output logic [3:0] digit,
  output logic [3:0] an,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned    CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    SLOT_P2_ONES = 2'd0,
    SLOT_P2_TENS = 2'd1,
    SLOT_P1_ONES = 2'd2,
    SLOT_P1_TENS = 2'd3
  } slot_e;

  logic [3:0]    p1_ones, p1_tens, p2_ones, p2_tens;
  logic [CW-1:0] refresh_cnt;
  slot_e         scan_idx;
  logic [6:0]    p1_val, p2_val;
  logic          p1_win, p2_win, freeze;
  logic [3:0]    digit_nxt, an_nxt;

  // {tens, ones} increment, saturating at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] != 4'd9)      r[3:0] = v[3:0] + 4'd1;
    else if (v[7:4] != 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    return r;
  endfunction

  function automatic logic [3:0] tens_glyph(input logic [3:0] tens);
`ifdef LEADING_ZERO_BLANK_EN
    return (tens == 4'd0) ? BLANK_CODE : tens;
`else
    return tens;
`endif
  endfunction

  // Scoring also freezes in the cycle a player reaches the win score,
  // before the registered game_over has caught up.
  always_comb begin
    p1_val = 7'(p1_tens) * 7'd10 + 7'(p1_ones);
    p2_val = 7'(p2_tens) * 7'd10 + 7'(p2_ones);
    p1_win = (p1_val == 7'(WIN_SCORE));
    p2_win = (p2_val == 7'(WIN_SCORE));
    freeze = game_over | p1_win | p2_win;
  end

  always_comb begin
    digit_nxt = p2_ones;
    an_nxt    = 4'b1110;
    unique case (scan_idx)
      SLOT_P2_ONES: begin digit_nxt = p2_ones;             an_nxt = 4'b1110; end
      SLOT_P2_TENS: begin digit_nxt = tens_glyph(p2_tens); an_nxt = 4'b1101; end
      SLOT_P1_ONES: begin digit_nxt = p1_ones;             an_nxt = 4'b1011; end
      SLOT_P1_TENS: begin digit_nxt = tens_glyph(p1_tens); an_nxt = 4'b0111; end
      default:      begin digit_nxt = p2_ones;             an_nxt = 4'b1110; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_ones     <= '0;
      p1_tens     <= '0;
      p2_ones     <= '0;
      p2_tens     <= '0;
      refresh_cnt <= '0;
      scan_idx    <= SLOT_P2_ONES;
      digit       <= 4'h0;
      an          <= 4'b1110;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      if (refresh_cnt == CNT_MAX) begin
        refresh_cnt <= '0;
        scan_idx    <= slot_e'(scan_idx + 2'd1);
      end else begin
        refresh_cnt <= refresh_cnt + CW'(1);
      end

      if (clr_scores) begin
        p1_ones   <= '0;
        p1_tens   <= '0;
        p2_ones   <= '0;
        p2_tens   <= '0;
        game_over <= 1'b0;
        winner    <= 1'b0;
      end else begin
        if (p1_point && !freeze) {p1_tens, p1_ones} <= bcd_inc({p1_tens, p1_ones});
        if (p2_point && !freeze) {p2_tens, p2_ones} <= bcd_inc({p2_tens, p2_ones});
        game_over <= p1_win | p2_win;
        winner    <= !p1_win && p2_win;
      end

      digit <= digit_nxt;
      an    <= an_nxt;
    end
  end

endmodule

// File: tb/tb_score_scan_mux.sv
// Directed bench for score_scan_mux: two instances (WIN_SCORE 99 and 11) sharing stimulus.
// Honours LEADING_ZERO_BLANK_EN for expected tens-digit glyphs.
module tb_score_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic       clr_scores = 1'b0;
  logic [3:0] digit_a, an_a, digit_b, an_b;
  logic       go_a, win_a, go_b, win_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] TENS_ZERO = 4'hF;
`else
  localparam logic [3:0] TENS_ZERO = 4'h0;
`endif

  always #5 clk = ~clk;

  score_scan_mux #(.REFRESH_DIV(4), .WIN_SCORE(99), .BLANK_CODE(4'hF)) dut_a (
    .clk(clk), .rst_n(rst_n), .p1_point(p1_point), .p2_point(p2_point),
    .clr_scores(clr_scores), .digit(digit_a), .an(an_a),
    .game_over(go_a), .winner(win_a)
  );

  score_scan_mux #(.REFRESH_DIV(4), .WIN_SCORE(11), .BLANK_CODE(4'hF)) dut_b (
    .clk(clk), .rst_n(rst_n), .p1_point(p1_point), .p2_point(p2_point),
    .clr_scores(clr_scores), .digit(digit_b), .an(an_b),
    .game_over(go_b), .winner(win_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse followed by one idle cycle
  task automatic pulse(input logic a, input logic b, input logic c);
    p1_point   = a;
    p2_point   = b;
    clr_scores = c;
    tick();
    p1_point   = 1'b0;
    p2_point   = 1'b0;
    clr_scores = 1'b0;
    tick();
  endtask

  task automatic wait_slot(input logic [3:0] want, input string tag);
    for (int i = 0; i < 40 && an_a !== want; i++) tick();
    check({tag, "_an"}, an_a, want);
  endtask

  function automatic logic [3:0] an_of(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  function automatic logic [3:0] zero_glyph(input int idx);
    return (idx % 2 == 1) ? TENS_ZERO : 4'h0;
  endfunction

  initial begin
    // T1: reset and scan rotation
    tick();
    tick();
    check("t1_rst_an", an_a, 4'b1110);
    check("t1_rst_digit", digit_a, 4'h0);
    check("t1_rst_go", go_a, 1'b0);
    check("t1_rst_win", win_b, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      check($sformatf("t1_an_e%0d", e), an_a, an_of(((e - 1) / 4) % 4));
      check($sformatf("t1_dig_e%0d", e), digit_a, zero_glyph(((e - 1) / 4) % 4));
    end
    check("t1_an_b", an_b, an_a);

    // T2: three P1 points
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
    wait_slot(4'b1011, "t2_p1o");
    check("t2_p1_ones", digit_a, 4'h3);
    wait_slot(4'b0111, "t2_p1t");
    check("t2_p1_tens", digit_a, TENS_ZERO);

    // T3: P2 counts to 12 through the 9->10 carry (WIN_SCORE=99 instance)
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) pulse(1'b0, 1'b1, 1'b0);
    wait_slot(4'b1110, "t3_9o");
    check("t3_p2_9_ones", digit_a, 4'h9);
    pulse(1'b0, 1'b1, 1'b0);
    wait_slot(4'b1110, "t3_10o");
    check("t3_p2_10_ones", digit_a, 4'h0);
    wait_slot(4'b1101, "t3_10t");
    check("t3_p2_10_tens", digit_a, 4'h1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    wait_slot(4'b1110, "t3_12o");
    check("t3_p2_12_ones", digit_a, 4'h2);
    check("t3_b_frozen_ones", digit_b, 4'h1);
    wait_slot(4'b1101, "t3_12t");
    check("t3_p2_12_tens", digit_a, 4'h1);
    check("t3_go_a", go_a, 1'b0);
    check("t3_go_b", go_b, 1'b1);

    // T4: simultaneous points, then clear beating a point
    pulse(1'b0, 1'b0, 1'b1);
    check("t4_clr_go_b", go_b, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    wait_slot(4'b1011, "t4_p1o");
    check("t4_p1_ones", digit_a, 4'h1);
    wait_slot(4'b1110, "t4_p2o");
    check("t4_p2_ones", digit_a, 4'h1);
    pulse(1'b1, 1'b0, 1'b1);
    for (int s = 0; s < 4; s++) begin
      wait_slot(an_of(s), $sformatf("t4_clr_s%0d", s));
      check($sformatf("t4_clr_dig_s%0d", s), digit_a, zero_glyph(s));
    end
    check("t4_clr_go", go_b, 1'b0);

    // T5: P2 wins on the WIN_SCORE=11 instance
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1, 1'b0);
    check("t5_go_at10", go_b, 1'b0);
    p2_point = 1'b1;
    tick();
    p2_point = 1'b0;
    check("t5_go_same_edge", go_b, 1'b0);
    tick();
    check("t5_go", go_b, 1'b1);
    check("t5_winner", win_b, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    wait_slot(4'b1110, "t5_o");
    check("t5_frozen_ones", digit_b, 4'h1);
    wait_slot(4'b1101, "t5_t");
    check("t5_frozen_tens", digit_b, 4'h1);
    check("t5_go_hold", go_b, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    check("t5_clr_go", go_b, 1'b0);
    check("t5_clr_win", win_b, 1'b0);

    // Tie at 11: player 1 wins
    for (int i = 0; i < 11; i++) pulse(1'b1, 1'b1, 1'b0);
    check("tie_go", go_b, 1'b1);
    check("tie_winner", win_b, 1'b0);

    // T6: reset mid-scan with score 7:4
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1, 1'b0);
    wait_slot(4'b1011, "t6_pre");
    check("t6_pre_p1", digit_a, 4'h7);
    rst_n = 1'b0;
    tick();
    check("t6_rst_an", an_a, 4'b1110);
    check("t6_rst_digit", digit_a, 4'h0);
    check("t6_rst_go", go_b, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("t6_an_e%0d", e), an_a, an_of(((e - 1) / 4) % 4));
    end
    wait_slot(4'b1011, "t6_p1o");
    check("t6_p1_zero", digit_a, 4'h0);
    wait_slot(4'b1110, "t6_p2o");
    check("t6_p2_zero", digit_a, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
